// File: rtl/dcache_direct_mapped.sv
// ---------------------------------------------------------------------------
// dcache_direct_mapped
//   Direct-mapped, write-back, write-allocate data cache with 4-word blocks.
//   Misses are served from a 128-bit main memory through a ready handshake.
//   Data is stored exactly as delivered; no byte reordering happens here.
//
// Ports
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   proc_read      : processor read request
//   proc_write     : processor write request (wins when both are high)
//   proc_addr      : word address; [1:0] word in block, then index, then tag
//   proc_wdata     : write data
//   proc_stall     : request cannot complete this cycle
//   proc_rdata     : read data, valid when proc_read=1 and proc_stall=0
//   mem_read       : block fetch request (ALLOCATE)
//   mem_write      : block writeback request (WRITEBACK)
//   mem_addr       : block address {tag,index}
//   mem_wdata      : writeback block, word w at [32w+31:32w]
//   mem_rdata      : fetched block, same layout
//   mem_ready      : one-cycle completion pulse from memory
//
// Handshake: the processor holds its request stable while proc_stall=1; the
// request completes on the first rising edge where proc_stall=0. Towards
// memory, mem_read/mem_write stay high until the edge on which mem_ready=1,
// which completes that transfer. mem_ready outside a transfer is ignored.
// ---------------------------------------------------------------------------
module dcache_direct_mapped #(
   parameter int NUM_BLOCK_BIT = 3,
   parameter int TAG_BIT       = 28 - NUM_BLOCK_BIT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic         proc_stall,
   output logic [31:0]  proc_rdata,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);

   localparam int NUM_BLOCKS = 1 << NUM_BLOCK_BIT;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   state_t state;

   logic [127:0]         data_arr [NUM_BLOCKS];
   logic [TAG_BIT-1:0]   tag_arr  [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] valid;
   logic [NUM_BLOCKS-1:0] dirty;

   logic [NUM_BLOCK_BIT-1:0] idx;
   logic [TAG_BIT-1:0]       addr_tag;
   logic [1:0]               word_sel;
   logic [127:0]             cur_block;
   logic                     req;
   logic                     hit;
   logic                     write_hit;
   logic                     fill;

   assign idx       = proc_addr[NUM_BLOCK_BIT+1:2];
   assign addr_tag  = proc_addr[29:NUM_BLOCK_BIT+2];
   assign word_sel  = proc_addr[1:0];
   assign cur_block = data_arr[idx];

   assign req       = proc_read | proc_write;
   assign hit       = valid[idx] & (tag_arr[idx] == addr_tag);
   assign write_hit = (state == IDLE) & proc_write & hit;
   // Fill only from ALLOCATE; an async reset forces IDLE, so an abandoned
   // transfer can never write a partial block.
   assign fill      = (state == ALLOCATE) & mem_ready;

   assign proc_stall = req & ~((state == IDLE) & hit);
   assign proc_rdata = cur_block[{word_sel, 5'b0} +: 32];

   // Moore decode of the state register.
   assign mem_read  = (state == ALLOCATE);
   assign mem_write = (state == WRITEBACK);
   assign mem_addr  = (state == WRITEBACK) ? {tag_arr[idx], idx} : proc_addr[29:2];
   assign mem_wdata = cur_block;

   // Control state: FSM plus valid/dirty bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_hit) begin
                  dirty[idx] <= 1'b1;
               end else if (req && !hit) begin
                  if (valid[idx] && dirty[idx]) state <= WRITEBACK;
                  else                          state <= ALLOCATE;
               end
            end
            WRITEBACK: begin
               if (mem_ready) state <= ALLOCATE;
            end
            ALLOCATE: begin
               if (mem_ready) begin
                  valid[idx] <= 1'b1;
                  dirty[idx] <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage arrays carry no reset; valid bits qualify their contents.
   always_ff @(posedge clk) begin
      if (fill) begin
         data_arr[idx] <= mem_rdata;
         tag_arr[idx]  <= addr_tag;
      end else if (write_hit) begin
         data_arr[idx][{word_sel, 5'b0} +: 32] <= proc_wdata;
      end
   end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// ---------------------------------------------------------------------------
// tb_dcache_direct_mapped
//   Drives processor accesses into dcache_direct_mapped while a behavioural
//   memory answers fetches and writebacks after a programmable latency.
//   Expected read data and expected memory transfers are queued when an
//   access is issued and compared when the cache produces them.
// ---------------------------------------------------------------------------
module tb_dcache_direct_mapped;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic         proc_stall;
   logic [31:0]  proc_rdata;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int total = 0;
   int bad   = 0;
   int mem_lat = 4;
   bit both_seen = 1'b0;

   logic [127:0] mem_model [logic [27:0]];
   logic [31:0]  exp_q[$];
   // {is_write, block address, writeback data (zero for fetches)}
   logic [156:0] exp_mem_q[$];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   dcache_direct_mapped dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_stall (proc_stall),
      .proc_rdata (proc_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   // Unique content for any block not explicitly loaded.
   function automatic logic [127:0] default_block(input logic [27:0] a);
      return {2'b10, a, 2'd3, 2'b10, a, 2'd2, 2'b10, a, 2'd1, 2'b10, a, 2'd0};
   endfunction

   // ---------------- memory responder / transfer scoreboard ----------------
   initial begin : mem_responder
      int cnt;
      logic [1:0]   kind;
      logic [1:0]   prev_kind;
      logic [156:0] obs;
      logic [156:0] e;
      cnt = 0;
      prev_kind = 2'd0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_read && mem_write) both_seen = 1'b1;
         kind = mem_write ? 2'd2 : (mem_read ? 2'd1 : 2'd0);
         if (kind == 2'd0)                         cnt = 0;
         else if (kind != prev_kind || mem_ready)  cnt = 1;
         else                                      cnt = cnt + 1;
         prev_kind = kind;
         mem_ready = 1'b0;
         if (kind != 2'd0 && cnt == mem_lat) begin
            mem_ready = 1'b1;
            obs = {mem_write, mem_addr, (mem_write ? mem_wdata : 128'h0)};
            if (mem_write) mem_model[mem_addr] = mem_wdata;
            else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr]
                                                        : default_block(mem_addr);
            total++;
            if (exp_mem_q.size() == 0) begin
               bad++;
               $display("FAIL mem_txn: unexpected transfer wr=%0b addr=%h, required none", mem_write, mem_addr);
            end else begin
               e = exp_mem_q.pop_front();
               if (obs !== e) begin
                  bad++;
                  $display("FAIL mem_txn: got wr=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                           obs[156], obs[155:128], obs[127:0], e[156], e[155:128], e[127:0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic access(input logic rd, input logic wr, input logic [29:0] addr,
                         input logic [31:0] wdata, output int stalls,
                         output logic [31:0] rdata);
      @(posedge clk);
      #1;
      proc_read  = rd;
      proc_write = wr;
      proc_addr  = addr;
      proc_wdata = wdata;
      stalls = 0;
      @(negedge clk);
      while (proc_stall && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      rdata = proc_rdata;
      if (stalls >= 200) begin
         total++;
         bad++;
         $display("FAIL access_timeout: addr=%h stall=1 after %0d cycles, required 0", addr, stalls);
      end
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (proc_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b required 0", proc_stall); end
      total++;
      if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read: got %b required 0", mem_read); end
      total++;
      if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write: got %b required 0", mem_write); end
      rst_n = 1'b1;
   endtask

   task automatic test_clean_miss();
      int st;
      logic [31:0] rd;
      logic [31:0] e;
      mem_lat = 4;
      mem_model[28'h4] = {32'h3, 32'h2, 32'h1, 32'h0};
      exp_q.push_back(32'h0);
      exp_mem_q.push_back({1'b0, 28'h4, 128'h0});
      access(1'b1, 1'b0, 30'h10, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e) begin bad++; $display("FAIL clean_miss_rdata: got %h required %h", rd, e); end
      total++;
      if (st !== 5) begin bad++; $display("FAIL clean_miss_stall: got %0d required 5", st); end
      total++;
      if (exp_mem_q.size() !== 0) begin bad++; $display("FAIL clean_miss_fetch: %0d transfers missing", exp_mem_q.size()); end
   endtask

   task automatic test_back_to_back();
      int st;
      logic [31:0] rd;
      logic [31:0] e;
      exp_q.push_back(32'h1);
      access(1'b1, 1'b0, 30'h11, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || st !== 0) begin bad++; $display("FAIL b2b_first: got data=%h stall=%0d required data=%h stall=0", rd, st, e); end
      exp_q.push_back(32'h3);
      access(1'b1, 1'b0, 30'h13, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || st !== 0) begin bad++; $display("FAIL b2b_second: got data=%h stall=%0d required data=%h stall=0", rd, st, e); end
   endtask

   task automatic test_write_hit();
      int st;
      logic [31:0] rd;
      logic [31:0] e;
      access(1'b0, 1'b1, 30'h12, 32'hDEADBEEF, st, rd);
      total++;
      if (st !== 0) begin bad++; $display("FAIL write_hit_stall: got %0d required 0", st); end
      exp_q.push_back(32'hDEADBEEF);
      access(1'b1, 1'b0, 30'h12, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || st !== 0) begin bad++; $display("FAIL write_hit_readback: got data=%h stall=%0d required data=%h stall=0", rd, st, e); end
      go_idle();
   endtask

   task automatic test_dirty_evict();
      int st;
      logic [31:0] rd;
      logic [31:0] e;
      logic [127:0] blk;
      mem_lat = 3;
      blk = default_block(28'h24);
      exp_mem_q.push_back({1'b1, 28'h4, {32'h3, 32'hDEADBEEF, 32'h1, 32'h0}});
      exp_mem_q.push_back({1'b0, 28'h24, 128'h0});
      exp_q.push_back(blk[31:0]);
      access(1'b1, 1'b0, 30'h90, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e) begin bad++; $display("FAIL dirty_evict_rdata: got %h required %h", rd, e); end
      total++;
      if (st !== 7) begin bad++; $display("FAIL dirty_evict_stall: got %0d required 7", st); end
      total++;
      if (exp_mem_q.size() !== 0) begin bad++; $display("FAIL dirty_evict_txns: %0d transfers missing", exp_mem_q.size()); end
      exp_q.push_back(blk[63:32]);
      access(1'b1, 1'b0, 30'h91, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || st !== 0) begin bad++; $display("FAIL dirty_evict_rehit: got data=%h stall=%0d required data=%h stall=0", rd, st, e); end
      go_idle();
   endtask

   task automatic test_write_miss();
      int st;
      logic [31:0] rd;
      logic [31:0] e;
      logic [127:0] blk10;
      logic [127:0] blk30;
      mem_lat = 2;
      blk10 = default_block(28'h10);
      blk30 = default_block(28'h30);
      exp_mem_q.push_back({1'b0, 28'h10, 128'h0});
      access(1'b0, 1'b1, 30'h40, 32'hCAFE0040, st, rd);
      total++;
      if (st !== 3) begin bad++; $display("FAIL write_miss_stall: got %0d required 3", st); end
      total++;
      if (exp_mem_q.size() !== 0) begin bad++; $display("FAIL write_miss_fetch: %0d transfers missing", exp_mem_q.size()); end
      exp_q.push_back(blk10[63:32]);
      access(1'b1, 1'b0, 30'h41, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || st !== 0) begin bad++; $display("FAIL write_miss_neighbour: got data=%h stall=%0d required data=%h stall=0", rd, st, e); end
      exp_mem_q.push_back({1'b1, 28'h10, {blk10[127:32], 32'hCAFE0040}});
      exp_mem_q.push_back({1'b0, 28'h30, 128'h0});
      exp_q.push_back(blk30[31:0]);
      access(1'b1, 1'b0, 30'hC0, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || st !== 5) begin bad++; $display("FAIL write_miss_evict: got data=%h stall=%0d required data=%h stall=5", rd, st, e); end
      total++;
      if (exp_mem_q.size() !== 0) begin bad++; $display("FAIL write_miss_evict_txns: %0d transfers missing", exp_mem_q.size()); end
      go_idle();
   endtask

   task automatic test_reset_mid_allocate();
      int st;
      logic [31:0] rd;
      logic [31:0] e;
      logic [127:0] blk40;
      logic [127:0] blk24;
      mem_lat = 50;
      @(posedge clk);
      #1;
      proc_read  = 1'b1;
      proc_write = 1'b0;
      proc_addr  = 30'h100;
      repeat (3) @(negedge clk);
      total++;
      if (mem_read !== 1'b1) begin bad++; $display("FAIL abort_pre_mem_read: got %b required 1", mem_read); end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         bad++;
         $display("FAIL abort_async_drop: got mem_read=%b mem_write=%b required 0 0", mem_read, mem_write);
      end
      proc_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_lat = 2;
      blk40 = default_block(28'h40);
      exp_mem_q.push_back({1'b0, 28'h40, 128'h0});
      exp_q.push_back(blk40[31:0]);
      access(1'b1, 1'b0, 30'h100, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || st !== 3) begin bad++; $display("FAIL abort_refetch: got data=%h stall=%0d required data=%h stall=3", rd, st, e); end
      blk24 = default_block(28'h24);
      exp_mem_q.push_back({1'b0, 28'h24, 128'h0});
      exp_q.push_back(blk24[31:0]);
      access(1'b1, 1'b0, 30'h90, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || st !== 3) begin bad++; $display("FAIL abort_valid_cleared: got data=%h stall=%0d required data=%h stall=3", rd, st, e); end
      total++;
      if (exp_mem_q.size() !== 0) begin bad++; $display("FAIL abort_txns: %0d transfers missing", exp_mem_q.size()); end
      go_idle();
   endtask

   task automatic test_read_write_both();
      int st;
      logic [31:0] rd;
      logic [31:0] e;
      logic [127:0] blk40;
      blk40 = default_block(28'h40);
      access(1'b1, 1'b1, 30'h102, 32'h12345678, st, rd);
      total++;
      if (st !== 0) begin bad++; $display("FAIL both_stall: got %0d required 0", st); end
      exp_q.push_back(32'h12345678);
      access(1'b1, 1'b0, 30'h102, 32'h0, st, rd);
      e = exp_q.pop_front();
      total++;
      if (rd !== e || st !== 0) begin bad++; $display("FAIL both_readback: got data=%h stall=%0d required data=%h stall=0", rd, st, e); end
      exp_mem_q.push_back({1'b1, 28'h40, {blk40[127:96], 32'h12345678, blk40[63:0]}});
      exp_mem_q.push_back({1'b0, 28'h0, 128'h0});
      access(1'b1, 1'b0, 30'h002, 32'h0, st, rd);
      total++;
      if (st !== 5) begin bad++; $display("FAIL both_dirty_evict: got stall=%0d required 5", st); end
      go_idle();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n      = 1'b0;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      test_reset();
      test_clean_miss();
      test_back_to_back();
      test_write_hit();
      test_dirty_evict();
      test_write_miss();
      test_reset_mid_allocate();
      test_read_write_both();
      repeat (4) @(negedge clk);
      total++;
      if (both_seen !== 1'b0) begin bad++; $display("FAIL mem_exclusive: mem_read and mem_write seen high together"); end
      total++;
      if (exp_mem_q.size() !== 0) begin bad++; $display("FAIL final_txns: %0d transfers missing", exp_mem_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcache_direct_mapped.md
Name: dcache_direct_mapped

Overview:
- Data-cache responder for the pipeline's D-cache port. It answers processor word reads and writes.
- Direct-mapped, write-back, write-allocate, 4 words per block.
- Misses are served from a 128-bit-wide main memory through a ready handshake.
- Sits between the CPU's DCACHE_* port and the memory model. Stores data exactly as delivered; any byte swapping happens in the CPU.

Parameters:
- NUM_BLOCK_BIT, 3, log2 of block count (default 8 blocks). Index = proc_addr[NUM_BLOCK_BIT+1:2].
- TAG_BIT, 28-NUM_BLOCK_BIT, tag width. Tag = proc_addr[29:NUM_BLOCK_BIT+2].

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- proc_read  input  1  processor read request
- proc_write  input  1  processor write request
- proc_addr  input  30  processor word address; [1:0] = word within block
- proc_wdata  input  32  processor write data
- proc_stall  output  1  high while the request cannot complete this cycle
- proc_rdata  output  32  read data; valid only when proc_read=1 and proc_stall=0
- mem_read  output  1  block fetch request
- mem_write  output  1  block writeback request
- mem_addr  output  28  memory block address {tag,index}
- mem_wdata  output  128  writeback block; word w at bits [32w+31:32w]
- mem_rdata  input  128  fetched block, same word layout
- mem_ready  input  1  one-cycle pulse: memory has completed the current request

Behaviour:
- Reset is asynchronous and active-low: clk and rst_n, async active-low, exactly as decided.
  - Clears all valid and dirty bits and forces state to IDLE.
  - mem_read=0, mem_write=0 immediately.
  - Data/tag arrays are not required to reset.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE abandons the transfer. No partial block is marked valid.
- Request definition: req = proc_read | proc_write. If both are high, write takes priority and read data is don't-care.
- Hit: valid[idx] and tag[idx]==addr tag, evaluated combinationally.
- Output decode from state (Moore):
  - mem_read = (state==ALLOCATE)
  - mem_write = (state==WRITEBACK)
  - mem_addr and mem_wdata are derived from the state register and the held proc_addr/arrays.
- proc_stall = req & ~(state==IDLE & hit), combinational.
- States:
  - IDLE
    - No req: stall=0, nothing changes.
    - Read hit: proc_rdata = data[idx][word], combinational, zero-latency.
    - Write hit: on the edge, write word, set dirty[idx]=1. Stall=0.
    - Miss, valid & dirty: go to WRITEBACK.
    - Miss otherwise: go to ALLOCATE.
  - WRITEBACK
    - mem_write=1, mem_addr = {tag[idx], idx}, mem_wdata = data[idx].
    - Hold until mem_ready=1, then go to ALLOCATE.
  - ALLOCATE
    - mem_read=1, mem_addr = proc_addr[29:2].
    - Hold until mem_ready=1. On that edge: data[idx] <= mem_rdata, tag <= addr tag, valid=1, dirty=0. Go to IDLE.
  - Back in IDLE the request now hits and completes as above. A write miss therefore fetches first, then merges the word and sets dirty.
- The processor holds proc_read/proc_write/proc_addr/proc_wdata stable while proc_stall=1. The controller indexes with the live proc_addr.
- mem_ready while in IDLE is ignored.
- mem_read and mem_write are never high together.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: 1 (IDLE) + L_mem (ALLOCATE) stall cycles.
  - Dirty miss: 1 + 2*L_mem.
  - L_mem = cycles from request to mem_ready inclusive.
- Index wrap: addresses with equal index and different tag conflict. No associativity.

Test Plan:
- Reset, then read 30'h10 with memory returning block {32'h3,32'h2,32'h1,32'h0} after 4 cycles:
  - Stall high 5 cycles; mem_read=1 with mem_addr=28'h4; mem_write never asserts.
  - Next cycle proc_rdata=32'h0 with stall=0.
- Read 30'h11 then 30'h13 immediately afterwards -> both hits, stall=0, rdata 32'h1 then 32'h3, no mem activity.
- Write 30'h12 with 32'hDEADBEEF (hit) -> stall=0. A subsequent read of 30'h12 returns 32'hDEADBEEF with no memory traffic.
- Read 30'h90 (same index 4, tag 4) after the dirty write:
  - WRITEBACK first: mem_write=1, mem_addr=28'h4, mem_wdata[95:64]=32'hDEADBEEF.
  - Then ALLOCATE: mem_read=1, mem_addr=28'h24.
  - Then hit. Total stall = 1+2*L_mem.
- Write miss to 30'h40 (clean line):
  - ALLOCATE fetch of 28'h10, then word 0 merged and dirty set.
  - A later evicting access to 30'hC0 writes back a block containing the written word.
- Pull rst_n low during ALLOCATE -> mem_read drops asynchronously. After release, re-reading the same address misses again and re-fetches.
- proc_read=proc_write=1 on a hit -> the write is performed with stall=0.
